// File: rtl/vga_pkg.sv
// vga_pkg: shared types and helpers for the VGA pattern engine.
//   mode_t        - pattern selector (SOLID, RAINBOW, BLIT, CHECKER)
//   state_t       - engine FSM states (IDLE, SCAN, FLUSH)
//   RB_*          - rainbow segment endpoint colors
//   expand_color  - widens a 3/12/24-bit image word to 24-bit RGB
package vga_pkg;

   typedef enum logic [1:0] {
      SOLID   = 2'd0,
      RAINBOW = 2'd1,
      BLIT    = 2'd2,
      CHECKER = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [23:0] RB_RED     = 24'hFF0000;
   localparam logic [23:0] RB_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] RB_GREEN   = 24'h00FF00;
   localparam logic [23:0] RB_CYAN    = 24'h00FFFF;
   localparam logic [23:0] RB_BLUE    = 24'h0000FF;
   localparam logic [23:0] RB_MAGENTA = 24'hFF00FF;

   // word is the image word zero-extended to 24 bits; bits is its real width.
   function automatic logic [23:0] expand_color(input logic [23:0] word,
                                                input int unsigned bits);
      logic [23:0] rgb;
      case (bits)
         3:       rgb = {{8{word[2]}}, {8{word[1]}}, {8{word[0]}}};
         12:      rgb = {word[11:8], word[11:8], word[7:4], word[7:4],
                         word[3:0], word[3:0]};
         default: rgb = word;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/vga_addr_calc.sv
// vga_addr_calc: combinational image address y*COLS + x.
//   x    in  nX : absolute column
//   y    in  nY : absolute row
//   addr out Mn : memory address (sum formed at Mn+1 bits, then truncated)
// The common VGA widths are built from two shifts; anything else multiplies.
module vga_addr_calc
   import vga_pkg::*;
#(
   parameter int nX   = 8,
   parameter int nY   = nX - 1,
   parameter int Mn   = 15,
   parameter int COLS = 160
) (
   input  logic [nX-1:0] x,
   input  logic [nY-1:0] y,
   output logic [Mn-1:0] addr
);

   localparam int AW = Mn + 1;

   logic [AW-1:0] xw;
   logic [AW-1:0] yw;
   logic [AW-1:0] sum;

   assign xw = AW'(x);
   assign yw = AW'(y);

   generate
      if (COLS == 160) begin : g_160
         assign sum = (yw << 7) + (yw << 5) + xw;
      end else if (COLS == 320) begin : g_320
         assign sum = (yw << 8) + (yw << 6) + xw;
      end else if (COLS == 640) begin : g_640
         assign sum = (yw << 9) + (yw << 7) + xw;
      end else begin : g_mul
         assign sum = yw * AW'(COLS) + xw;
      end
   endgenerate

   assign addr = Mn'(sum);

endmodule

// File: rtl/vga_pattern_engine.sv
// vga_pattern_engine: sweeps a rectangle one pixel per clock and emits
// VGA pixel writes in SOLID, RAINBOW, BLIT or CHECKER mode.
//   CLOCK_50, Reset      : clock, async active-high reset
//   start, mode          : request (sampled in IDLE only) and pattern select
//   x0/x1, y0/y1         : inclusive rectangle bounds
//   fg_color             : color for SOLID / CHECKER
//   mem_addr, mem_data   : synchronous image memory port (1-cycle latency)
//   VGA_X/Y/COLOR, plot  : pixel write, one register stage after stage 0
//   cur_color            : current rainbow sweep color
//   busy, done, err      : status; done is a pulse, err valid with done
module vga_pattern_engine
   import vga_pkg::*;
#(
   parameter int          nX       = 8,
   parameter int          nY       = nX - 1,
   parameter int          COLS     = 160,
   parameter int          ROWS     = 120,
   parameter int          Mn       = 15,
   parameter int          MEM_BITS = 12,
   parameter logic [7:0]  STEP     = 8'h11
) (
   input  logic                CLOCK_50,
   input  logic                Reset,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [nX-1:0]       x0,
   input  logic [nX-1:0]       x1,
   input  logic [nY-1:0]       y0,
   input  logic [nY-1:0]       y1,
   input  logic [23:0]         fg_color,
   output logic [Mn-1:0]       mem_addr,
   input  logic [MEM_BITS-1:0] mem_data,
   output logic [nX-1:0]       VGA_X,
   output logic [nY-1:0]       VGA_Y,
   output logic [23:0]         VGA_COLOR,
   output logic                plot,
   output logic [23:0]         cur_color,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [nX:0] COLS_X = (nX + 1)'(COLS);
   localparam logic [nY:0] ROWS_Y = (nY + 1)'(ROWS);
   localparam logic [2:0]  SEG_LAST = 3'd6;

   state_t        state;
   mode_t         mode_r;
   logic [nX-1:0] x0_r, x1_r, x;
   logic [nY-1:0] y0_r, y1_r, y;
   logic [23:0]   fg_r;
   logic [2:0]    seg;          // rainbow segment; SEG_LAST marks the final sweep
   logic [23:0]   color_q;
   logic          out_blit;

   logic          bad_req;
   logic          last_x;
   logic          last_pix;
   logic [23:0]   s0_color;
   logic [23:0]   rb_next;
   logic [23:0]   rb_end;

   vga_addr_calc #(
      .nX  (nX),
      .nY  (nY),
      .Mn  (Mn),
      .COLS(COLS)
   ) u_addr (
      .x   (x),
      .y   (y),
      .addr(mem_addr)
   );

   assign bad_req  = (x0 > x1) || (y0 > y1) ||
                     ({1'b0, x1} >= COLS_X) || ({1'b0, y1} >= ROWS_Y);
   assign last_x   = (x == x1_r);
   assign last_pix = last_x && (y == y1_r);

   // Stage-0 color; BLIT color is formed one stage later from mem_data.
   always_comb begin
      s0_color = '0;
      case (mode_r)
         SOLID:   s0_color = fg_r;
         RAINBOW: s0_color = cur_color;
         CHECKER: s0_color = (x[3] ^ y[3]) ? ~fg_r : fg_r;
         default: s0_color = '0;
      endcase
   end

   // Next rainbow color and the endpoint that closes the current segment.
   always_comb begin
      rb_next = cur_color;
      rb_end  = cur_color;
      case (seg)
         3'd0: begin
            rb_next = {cur_color[23:16], cur_color[15:8] + STEP, cur_color[7:0]};
            rb_end  = RB_YELLOW;
         end
         3'd1: begin
            rb_next = {cur_color[23:16] - STEP, cur_color[15:8], cur_color[7:0]};
            rb_end  = RB_GREEN;
         end
         3'd2: begin
            rb_next = {cur_color[23:16], cur_color[15:8], cur_color[7:0] + STEP};
            rb_end  = RB_CYAN;
         end
         3'd3: begin
            rb_next = {cur_color[23:16], cur_color[15:8] - STEP, cur_color[7:0]};
            rb_end  = RB_BLUE;
         end
         3'd4: begin
            rb_next = {cur_color[23:16] + STEP, cur_color[15:8], cur_color[7:0]};
            rb_end  = RB_MAGENTA;
         end
         3'd5: begin
            rb_next = {cur_color[23:16], cur_color[15:8], cur_color[7:0] - STEP};
            rb_end  = RB_RED;
         end
         default: begin
            rb_next = cur_color;
            rb_end  = cur_color;
         end
      endcase
   end

   // Memory data arrives in the output stage, so BLIT bypasses color_q.
   assign VGA_COLOR = out_blit ? expand_color(24'(mem_data), MEM_BITS) : color_q;

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         mode_r    <= SOLID;
         x0_r      <= '0;
         x1_r      <= '0;
         y0_r      <= '0;
         y1_r      <= '0;
         fg_r      <= '0;
         x         <= '0;
         y         <= '0;
         seg       <= '0;
         cur_color <= RB_RED;
         color_q   <= '0;
         out_blit  <= 1'b0;
         VGA_X     <= '0;
         VGA_Y     <= '0;
         plot      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         plot     <= (state == SCAN);
         out_blit <= (state == SCAN) && (mode_r == BLIT);
         if (state == SCAN) begin
            VGA_X   <= x;
            VGA_Y   <= y;
            color_q <= s0_color;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (bad_req) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else begin
                     mode_r    <= mode_t'(mode);
                     x0_r      <= x0;
                     x1_r      <= x1;
                     y0_r      <= y0;
                     y1_r      <= y1;
                     fg_r      <= fg_color;
                     x         <= x0;
                     y         <= y0;
                     seg       <= '0;
                     cur_color <= RB_RED;
                     busy      <= 1'b1;
                     state     <= SCAN;
                  end
               end
            end

            SCAN: begin
               if (last_x) begin
                  x <= x0_r;
                  if (last_pix) begin
                     y <= y0_r;
                     // A rainbow restarts the raster with the next color
                     // until the final FF0000 sweep has been emitted.
                     if ((mode_r == RAINBOW) && (seg != SEG_LAST)) begin
                        cur_color <= rb_next;
                        if (rb_next == rb_end) begin
                           seg <= seg + 3'd1;
                        end
                     end else begin
                        state <= FLUSH;
                     end
                  end else begin
                     y <= y + 1'b1;
                  end
               end else begin
                  x <= x + 1'b1;
               end
            end

            FLUSH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// tb_vga_pattern_engine: directed scoreboard bench for vga_pattern_engine.
// Expected pixels are queued when a job is started and popped on each plot.
module tb_vga_pattern_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [7:0]  x0, x1;
   logic [6:0]  y0, y1;
   logic [23:0] fg_color;
   logic [14:0] mem_addr;
   logic [11:0] mem_data;
   logic [7:0]  VGA_X;
   logic [6:0]  VGA_Y;
   logic [23:0] VGA_COLOR;
   logic        plot;
   logic [23:0] cur_color;
   logic        busy, done, err;

   vga_pattern_engine #(
      .nX(8), .nY(7), .COLS(160), .ROWS(120), .Mn(15), .MEM_BITS(12), .STEP(8'h11)
   ) dut (
      .CLOCK_50 (clk),
      .Reset    (rst),
      .start    (start),
      .mode     (mode),
      .x0       (x0),
      .x1       (x1),
      .y0       (y0),
      .y1       (y1),
      .fg_color (fg_color),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .VGA_X    (VGA_X),
      .VGA_Y    (VGA_Y),
      .VGA_COLOR(VGA_COLOR),
      .plot     (plot),
      .cur_color(cur_color),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Synchronous image memory whose word is the low 12 address bits.
   always @(posedge clk) mem_data <= mem_addr[11:0];

   typedef struct {
      logic [7:0]  x;
      logic [6:0]  y;
      logic [23:0] c;
   } pix_t;

   pix_t q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Rainbow color of sweep s (0-based) by interpolating between endpoints.
   function automatic logic [23:0] rb_color(input int s);
      int p, j;
      if (s == 0) return 24'hFF0000;
      p = (s - 1) / 15;
      j = ((s - 1) % 15 + 1) * 17;
      case (p)
         0:       return 24'((255 << 16) | (j << 8));
         1:       return 24'(((255 - j) << 16) | (255 << 8));
         2:       return 24'((255 << 8) | j);
         3:       return 24'(((255 - j) << 8) | 255);
         4:       return 24'((j << 16) | 255);
         default: return 24'((255 << 16) | (255 - j));
      endcase
   endfunction

   function automatic logic [23:0] exp_color(input logic [1:0] m, input int s,
                                             input int px, input int py,
                                             input logic [23:0] fg);
      int a, r, g, b;
      case (m)
         2'd0: return fg;
         2'd1: return rb_color(s);
         2'd2: begin
            a = (py * 160 + px) & 'hFFF;
            r = ((a >> 8) & 15) * 17;
            g = ((a >> 4) & 15) * 17;
            b = (a & 15) * 17;
            return 24'((r << 16) | (g << 8) | b);
         end
         default: return (((px ^ py) & 8) != 0) ? ~fg : fg;
      endcase
   endfunction

   task automatic run_job(input string name, input logic [1:0] m,
                          input int ax0, input int ax1, input int ay0, input int ay1,
                          input logic [23:0] fg, input int poke);
      int          sweeps, n, first, done_n, exp_done, plots, total;
      int          gaps;
      logic [14:0] prev_addr;
      pix_t        e;
      sweeps = (m == 2'd1) ? 91 : 1;
      for (int s = 0; s < sweeps; s++)
         for (int yy = ay0; yy <= ay1; yy++)
            for (int xx = ax0; xx <= ax1; xx++) begin
               e.x = 8'(xx);
               e.y = 7'(yy);
               e.c = exp_color(m, s, xx, yy, fg);
               q.push_back(e);
            end
      total    = q.size();
      exp_done = total + 2;

      mode = m; x0 = 8'(ax0); x1 = 8'(ax1); y0 = 7'(ay0); y1 = 7'(ay1); fg_color = fg;
      start = 1'b1;
      tick;
      start = 1'b0;
      // Scrambled inputs must not affect the running job.
      mode = 2'd0; x0 = 8'd0; x1 = 8'd1; y0 = 7'd0; y1 = 7'd0; fg_color = ~fg;

      n = 1; first = -1; done_n = -1; plots = 0; gaps = 0; prev_addr = '0;
      check({name, "_busy_k1"}, 32'(busy), 32'd1);
      while (n < exp_done + 20) begin
         start = (n == poke);
         if (plot) begin
            plots++;
            if (first < 0) first = n;
            if (q.size() != 0) begin
               e = q.pop_front();
               check({name, "_x"}, 32'(VGA_X), 32'(e.x));
               check({name, "_y"}, 32'(VGA_Y), 32'(e.y));
               check({name, "_color"}, 32'(VGA_COLOR), 32'(e.c));
               if (m == 2'd2)
                  check({name, "_addr"}, 32'(prev_addr), 32'(int'(e.y) * 160 + int'(e.x)));
            end
         end else if (first >= 0 && q.size() != 0) begin
            gaps++;
         end
         if (done) begin
            done_n = n;
            check({name, "_err"}, 32'(err), 32'd0);
            check({name, "_busy_done"}, 32'(busy), 32'd0);
            break;
         end
         prev_addr = mem_addr;
         tick;
         n++;
      end
      start = 1'b0;
      check({name, "_first_plot"}, 32'(first), 32'd2);
      check({name, "_done_cycle"}, 32'(done_n), 32'(exp_done));
      check({name, "_plots"}, 32'(plots), 32'(total));
      check({name, "_gaps"}, 32'(gaps), 32'd0);
      check({name, "_left"}, 32'(q.size()), 32'd0);
      q.delete();
   endtask

   task automatic reject_job(input string name, input int ax0, input int ax1,
                             input int ay0, input int ay1);
      mode = 2'd0; x0 = 8'(ax0); x1 = 8'(ax1); y0 = 7'(ay0); y1 = 7'(ay1);
      fg_color = 24'h00FF00;
      start = 1'b1;
      tick;
      start = 1'b0;
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_err"}, 32'(err), 32'd1);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_plot"}, 32'(plot), 32'd0);
      tick;
      check({name, "_done2"}, 32'(done), 32'd0);
      check({name, "_busy2"}, 32'(busy), 32'd0);
      tick;
      check({name, "_plot2"}, 32'(plot), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0;
      x0 = '0; x1 = '0; y0 = '0; y1 = '0; fg_color = '0;
      tick;
      tick;
      check("rst_plot", 32'(plot), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_vx", 32'(VGA_X), 32'd0);
      check("rst_vy", 32'(VGA_Y), 32'd0);
      check("rst_vc", 32'(VGA_COLOR), 32'd0);
      check("rst_cur", 32'(cur_color), 32'hFF0000);
      check("rst_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      tick;

      run_job("solid", 2'd0, 2, 4, 3, 4, 24'h123456, 3);
      run_job("checker", 2'd3, 0, 15, 0, 15, 24'hFF0000, 0);
      run_job("blit_row", 2'd2, 0, 159, 0, 0, 24'h000000, 0);
      run_job("blit_blk", 2'd2, 150, 159, 100, 101, 24'h000000, 0);
      run_job("corner", 2'd0, 159, 159, 119, 119, 24'h0F0F0F, 0);
      run_job("rainbow", 2'd1, 10, 11, 20, 20, 24'h000000, 5);
      check("rainbow_cur_end", 32'(cur_color), 32'hFF0000);

      reject_job("rej_x", 5, 4, 0, 0);
      reject_job("rej_cols", 0, 160, 0, 0);
      reject_job("rej_y", 0, 0, 9, 8);
      reject_job("rej_rows", 0, 0, 0, 120);

      // Reset asserted between clock edges in the middle of a rainbow.
      mode = 2'd1; x0 = 8'd3; x1 = 8'd4; y0 = 7'd5; y1 = 7'd5; fg_color = 24'h0;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (10) tick;
      check("pre_rst_plot", 32'(plot), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_plot", 32'(plot), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_vx", 32'(VGA_X), 32'd0);
      check("mid_rst_vy", 32'(VGA_Y), 32'd0);
      check("mid_rst_vc", 32'(VGA_COLOR), 32'd0);
      check("mid_rst_cur", 32'(cur_color), 32'hFF0000);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      #2 rst = 1'b0;
      tick;
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_plot", 32'(plot), 32'd0);
      run_job("after_rst", 2'd0, 0, 3, 0, 1, 24'hABCDEF, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_pattern_engine.md
# vga_pattern_engine

Parametrised rectangle pattern generator for the VGA pixel-write interface of the DESim display: on `start` it sweeps a user-defined rectangle one pixel per clock and emits (x, y, color, plot) writes. Four modes are supported: solid fill, multi-sweep rainbow ramp, memory image blit and checkerboard. It is the next-generation demo/test-pattern driver between board controls (KEY/SW/HEX logic) and the VGA adapter, and targets any resolution selected in `resolution.sv`.

## Interface
- `nX`, 8: x coordinate width (10/9/8 for 640/320/160 columns).
- `nY`, nX-1: y coordinate width.
- `COLS`, 160: screen columns; also the memory row pitch.
- `ROWS`, 120: screen rows.
- `Mn`, 15: memory address width; must satisfy 2^Mn >= COLS*ROWS.
- `MEM_BITS`, 12: image word width (3 or 12 or 24); expanded to 24-bit RGB.
- `STEP`, 8'h11: per-sweep rainbow component step; must divide 255.
- `CLOCK_50` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `mode` in 2: 0 SOLID, 1 RAINBOW, 2 BLIT, 3 CHECKER.
- `x0`, `x1` in nX: inclusive column bounds. `y0`, `y1` in nY: inclusive row bounds.
- `fg_color` in 24: color for SOLID/CHECKER.
- `mem_addr` out Mn: image memory read address (synchronous memory, 1-cycle read latency).
- `mem_data` in MEM_BITS: image memory read data.
- `VGA_X` out nX, `VGA_Y` out nY, `VGA_COLOR` out 24, `plot` out 1: pixel write.
- `cur_color` out 24: color of the current sweep, for HEX display.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1 (valid with `done`).

## Operation
- States: IDLE, SCAN, FLUSH. `start` in IDLE latches mode, bounds and `fg_color`; changes to the inputs after that are ignored until the next IDLE.
- Validation at `start`: if x0>x1, y0>y1, x1>=COLS or y1>=ROWS, the engine stays in IDLE and pulses `done`=`err`=1 on the next cycle, with no plots.
- SCAN raster order: x runs x0..x1; at x1 it wraps to x0 and y increments; at (x1, y1) the sweep ends. One pixel per clock, with no gaps.
- SOLID: one sweep with `fg_color`.
- CHECKER: one sweep; the color is `fg_color` when x[3]^y[3]=0, otherwise ~`fg_color`.
- BLIT: one sweep. `mem_addr` = y*COLS + x, using absolute coordinates and computed combinationally from the stage-0 coordinate.
  - 12-bit words expand by nibble duplication: {R,R,G,G,B,B}.
  - 3-bit words expand by replicating each bit eight times.
  - 24-bit words pass through unchanged.
- RAINBOW: repeated sweeps. `cur_color` starts at FF0000 and steps once at each sweep boundary through six segments:
  - +G to FFFF00.
  - −R to 00FF00.
  - +B to 00FFFF.
  - −G to 0000FF.
  - +R to FF00FF.
  - −B to FF0000.
  - The segment advances when its endpoint is reached. The final sweep is the one at FF0000 after the sixth segment.
  - Total sweeps = 6*(255/STEP)+1; this is 91 for STEP=8'h11.
- SCAN→FLUSH after the last stage-0 pixel. FLUSH→IDLE after one cycle, pulsing `done`=1, `err`=0.
- Rejection rules:
  - `start` while busy is ignored.
  - `mode` outside 0..3 is impossible (2 bits).
- Reset, including mid-sweep, returns to IDLE immediately. Output reset values:
  - `plot`, `busy`, `done`, `err` = 0.
  - `VGA_X`, `VGA_Y` = 0, `VGA_COLOR` = 0.
  - `cur_color` = FF0000.
  - `mem_addr` = 0.
- Arithmetic:
  - Address computed at Mn+1 bits, then truncated; it never overflows given the validation rule.
  - Rainbow component add/sub is 8-bit per channel, with no carry between channels.

## Timing
- `start` sampled at edge k leads to SCAN from k+1, with stage-0 coordinate (x0, y0) and `mem_addr` valid in cycle k+1.
- All modes have a uniform 1-cycle output register stage. `VGA_X`/`VGA_Y`/`VGA_COLOR`/`plot` for (x0, y0) are valid in cycle k+2; BLIT `mem_data` aligns with the same stage.
- `plot` is high for exactly W*H consecutive cycles per sweep, where W=x1−x0+1 and H=y1−y0+1. For RAINBOW this is back-to-back across sweeps, with the color changing exactly on the first pixel of each new sweep.
- `busy` is high from k+1 through the last `plot` cycle. `done` pulses in the cycle after the last `plot`.
- A new `start` is accepted in the `done` cycle.
- Rejected start: `done`/`err` asserted at k+1, and `busy` never rises.

## Structure
- Package `vga_pkg`:
  - `mode_t` enum (SOLID, RAINBOW, BLIT, CHECKER).
  - `state_t` enum (IDLE, SCAN, FLUSH).
  - Rainbow endpoint constants (FF0000, FFFF00, 00FF00, 00FFFF, 0000FF, FF00FF).
  - Function `expand_color(MEM_BITS word)` returning 24-bit RGB.
- Sub-module `vga_addr_calc` (parameters nX, nY, Mn, COLS): combinational y*COLS+x. It uses shift-add when COLS is 160/320/640 and a generic multiply otherwise.
- Top level contains the FSM, the x/y counters, the rainbow ramp register and the output stage.

## Test plan
- SOLID, (2,3)-(4,4), `fg_color`=123456 → plot high for 6 cycles from k+2, in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), all 123456; `done` at k+8.
- RAINBOW, full 160×120, STEP=8'h11 → 91 sweeps of 19200 plots each, with no gaps. Sweep colors: 1 FF0000, 2 FF1100, 16 FFFF00, 17 EEFF00; sweep 91 is FF0000. `done` once at the end.
- BLIT (0,0)-(159,0) with memory word = address[11:0] → `mem_addr` 0..159. At x=10 the memory word is 00A, so `VGA_COLOR`=0000AA, aligned with `VGA_X`=10.
- CHECKER (0,0)-(15,15), `fg_color`=FF0000 → pixel (7,7)=FF0000, (8,7)=00FFFF, (8,8)=FF0000.
- Errors: x0=5,x1=4 → `done`=`err`=1 at k+1, no plot. x1=COLS → same. `start` during busy → no effect.
- Reset asserted mid-sweep, asynchronously between edges → outputs 0 and `cur_color`=FF0000 immediately. After release, a fresh `start` runs normally.
